score_keeper_fsm: RTL and testbench
===================================

Name: score_keeper_fsm

Overview:
Game-rule controller that turns raw player push-buttons into the two score bytes driving the two-digit display sequencer. It debounces the buttons and applies point, undo and new-game events. It tracks serve rotation, detects the win condition and freezes scoring until a new game starts. It sits between the board's pushbutton inputs and the display controller's p1/p2 score inputs.

Parameters:
WIN_SCORE, 11, points needed to win (must be ≤ 99)
WIN_MARGIN, 2, required lead over the opponent to win
SERVE_SWAP, 2, points per serve turn before the server toggles (outside deuce)
DEBOUNCE_CYCLES, 65536, cycles a synchronized input must hold a new level before it is accepted

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
btn_p1_i  in  1  raw button, point to player 1, active-high, asynchronous
btn_p2_i  in  1  raw button, point to player 2
btn_undo_i  in  1  raw button, revert last point
btn_new_i  in  1  raw button, start new game
p1_score_o  out  8  player 1 score, binary, 0..99
p2_score_o  out  8  player 2 score, binary, 0..99
server_o  out  1  0 = player 1 serves, 1 = player 2 serves
winner_o  out  2  0 none, 1 player 1, 2 player 2
state_o  out  1  0 PLAY, 1 GAME_OVER

Behaviour:
- Reset, asynchronous:
  - scores 0, server_o 0, winner_o 0, state PLAY
  - first_server 0, serve_cnt 0, undo_valid 0
  - all debouncer stable levels 0
- Debounce, per button:
  - 2-FF synchronizer.
  - A counter increments while the synchronized level differs from the stable level; it clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronized level.
  - A 0→1 change of the stable level emits a one-cycle event pulse.
  - Pulse appears DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+4 cycles after the raw edge.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
  - Holding a button produces exactly one pulse.
- Event priority, same cycle: new > undo > p1 > p2. Lower-priority events in that cycle are dropped, not queued.
- All state updates are registered; outputs change on the clock edge after the pulse (1-cycle latency).
- PLAY, point to X:
  - If score_X = 99, ignore the event (no history change).
  - Otherwise save {p1, p2, server, serve_cnt} to the undo register, set undo_valid = 1, score_X += 1.
  - Deuce is computed on the pre-point scores: both ≥ WIN_SCORE-1.
  - If deuce, or serve_cnt = SERVE_SWAP-1: toggle server, serve_cnt = 0. Otherwise serve_cnt += 1.
- Win check, on the post-point scores in the same update:
  - Condition: score_X ≥ WIN_SCORE and score_X ≥ score_Y + WIN_MARGIN.
  - On win: state GAME_OVER, winner_o = X.
- GAME_OVER:
  - p1/p2 events ignored; scores, server and winner hold.
- Undo, both states:
  - If undo_valid, restore the saved tuple, clear undo_valid, state PLAY, winner_o 0.
  - If undo_valid = 0, ignore. Only one level of undo exists.
- New game, both states:
  - scores 0, winner 0, state PLAY, undo_valid 0, serve_cnt 0.
  - first_server toggles; server_o = new first_server.
- Reset asserted mid-game returns immediately to reset values. Debouncer counters clear, so a button held through reset deassertion produces one pulse after its debounce time.
- Width rule: win compare uses 9-bit sums (score_Y + WIN_MARGIN) so there is no wrap.

Decomposition:
- Shared package: state encoding (PLAY/GAME_OVER), winner codes (NONE/P1/P2), SCORE_MAX = 99.
- Sub-module button_debouncer (param DEBOUNCE_CYCLES; ports clk_i, rst_i, btn_i, pulse_o, level_o), instantiated 4×.
- The game FSM and undo register stay in the top.

Test Plan:
- DEBOUNCE_CYCLES=4. Raw p1 pulse 2 cycles wide → no score change. Raw p1 held 20 cycles → exactly one increment, p1_score_o=1.
- SERVE_SWAP=2, from reset. Points p1,p1,p2,p2 → server_o after each point: 0,1,1,0.
- WIN_SCORE=11. Drive 10-10, then p1, p1 → after 11-10 state_o=0 and server toggles every point; after 12-10 winner_o=1, state_o=1. A further p2 leaves 12-10.
- From 11-5 (GAME_OVER, winner 1): undo → 10-5, state PLAY, winner_o 0, server restored. Second undo → no change.
- Simultaneous new+p1 pulses at 3-4 → 0-0, server_o = 1 (first_server toggled), undo ignored afterward.
- Assert rst_i asynchronously mid-game at 7-3 with btn_p2_i held → immediately 0-0, server 0. After deassert, one p2 point after the debounce time → 0-1.

Source files
------------

// File: rtl/score_keeper_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package : score_keeper_fsm_pkg
// Brief   : Shared encodings for the score keeper: game state, winner codes
//           and the score ceiling.
// Rev     : 1.0
// ============================================================================
package score_keeper_fsm_pkg;

    typedef logic [7:0] score_t;

    localparam logic [0:0] c_ST_PLAY      = 1'b0;
    localparam logic [0:0] c_ST_GAME_OVER = 1'b1;

    localparam logic [1:0] c_WIN_NONE = 2'd0;
    localparam logic [1:0] c_WIN_P1   = 2'd1;
    localparam logic [1:0] c_WIN_P2   = 2'd2;

    localparam score_t c_SCORE_MAX = 8'd99;

endpackage : score_keeper_fsm_pkg
`default_nettype wire

// File: rtl/score_keeper_fsm_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module : button_debouncer
// Brief  : 2-FF synchronizer plus hold-time filter; emits a one-cycle pulse
//          on each accepted rising level.
// Rev    : 1.0
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o,
    output logic level_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 != r_stable) begin
                if (r_cnt == c_CNT_MAX) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                    // Only the press direction produces an event.
                    r_pulse  <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse_o = r_pulse;
    assign level_o = r_stable;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/score_keeper_fsm.sv
`default_nettype none
// ============================================================================
// Module : score_keeper_fsm
// Brief  : Debounced button front end, scoring rules, serve rotation, win
//          detection and single-level undo for a two-player game.
// Rev    : 1.0
// ============================================================================
module score_keeper_fsm
    import score_keeper_fsm_pkg::*;
#(
    parameter int WIN_SCORE       = 11,
    parameter int WIN_MARGIN      = 2,
    parameter int SERVE_SWAP      = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_p1_i,
    input  logic       btn_p2_i,
    input  logic       btn_undo_i,
    input  logic       btn_new_i,
    output logic [7:0] p1_score_o,
    output logic [7:0] p2_score_o,
    output logic       server_o,
    output logic [1:0] winner_o,
    output logic       state_o
);

    localparam int SC_W = (SERVE_SWAP > 1) ? $clog2(SERVE_SWAP) : 1;
    localparam logic [SC_W-1:0] c_SC_LAST  = SC_W'(SERVE_SWAP - 1);
    localparam score_t          c_DEUCE_AT = score_t'(WIN_SCORE - 1);
    localparam logic [8:0]      c_WIN_S9   = 9'(WIN_SCORE);
    localparam logic [8:0]      c_MARGIN9  = 9'(WIN_MARGIN);

    logic w_pulse_p1, w_pulse_p2, w_pulse_undo, w_pulse_new;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1 (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_p1_i),   .pulse_o(w_pulse_p1),   .level_o());
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2 (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_p2_i),   .pulse_o(w_pulse_p2),   .level_o());
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_undo (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_undo_i), .pulse_o(w_pulse_undo), .level_o());
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_new (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_new_i),  .pulse_o(w_pulse_new),  .level_o());

    score_t          r_p1, r_p2, r_sv_p1, r_sv_p2;
    logic            r_server, r_sv_server, r_first_server, r_undo_valid;
    logic [SC_W-1:0] r_serve_cnt, r_sv_serve_cnt;
    logic [1:0]      r_winner;
    logic [0:0]      r_state;

    // Priority resolution: new > undo > p1 > p2, losers are discarded.
    logic w_ev_new, w_ev_undo, w_ev_p1, w_ev_p2, w_do_point;
    assign w_ev_new   = w_pulse_new;
    assign w_ev_undo  = w_pulse_undo & ~w_pulse_new;
    assign w_ev_p1    = w_pulse_p1 & ~w_pulse_undo & ~w_pulse_new;
    assign w_ev_p2    = w_pulse_p2 & ~w_pulse_p1 & ~w_pulse_undo & ~w_pulse_new;
    assign w_do_point = (r_state == c_ST_PLAY) &&
                        ((w_ev_p1 && (r_p1 != c_SCORE_MAX)) ||
                         (w_ev_p2 && (r_p2 != c_SCORE_MAX)));

    score_t     w_p1_next, w_p2_next;
    logic [1:0] w_win_next;
    logic       w_deuce;

    always_comb begin
        w_p1_next  = r_p1;
        w_p2_next  = r_p2;
        w_win_next = c_WIN_NONE;
        w_deuce    = (r_p1 >= c_DEUCE_AT) && (r_p2 >= c_DEUCE_AT);
        if (w_ev_p1) begin
            w_p1_next = r_p1 + 8'd1;
            if (({1'b0, w_p1_next} >= c_WIN_S9) &&
                ({1'b0, w_p1_next} >= ({1'b0, r_p2} + c_MARGIN9)))
                w_win_next = c_WIN_P1;
        end else begin
            w_p2_next = r_p2 + 8'd1;
            if (({1'b0, w_p2_next} >= c_WIN_S9) &&
                ({1'b0, w_p2_next} >= ({1'b0, r_p1} + c_MARGIN9)))
                w_win_next = c_WIN_P2;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p1           <= '0;
            r_p2           <= '0;
            r_server       <= 1'b0;
            r_first_server <= 1'b0;
            r_serve_cnt    <= '0;
            r_winner       <= c_WIN_NONE;
            r_state        <= c_ST_PLAY;
            r_undo_valid   <= 1'b0;
            r_sv_p1        <= '0;
            r_sv_p2        <= '0;
            r_sv_server    <= 1'b0;
            r_sv_serve_cnt <= '0;
        end else if (w_ev_new) begin
            r_p1           <= '0;
            r_p2           <= '0;
            r_winner       <= c_WIN_NONE;
            r_state        <= c_ST_PLAY;
            r_undo_valid   <= 1'b0;
            r_serve_cnt    <= '0;
            r_first_server <= ~r_first_server;
            r_server       <= ~r_first_server;
        end else if (w_ev_undo) begin
            if (r_undo_valid) begin
                r_p1         <= r_sv_p1;
                r_p2         <= r_sv_p2;
                r_server     <= r_sv_server;
                r_serve_cnt  <= r_sv_serve_cnt;
                r_undo_valid <= 1'b0;
                r_state      <= c_ST_PLAY;
                r_winner     <= c_WIN_NONE;
            end
        end else if (w_do_point) begin
            r_sv_p1        <= r_p1;
            r_sv_p2        <= r_p2;
            r_sv_server    <= r_server;
            r_sv_serve_cnt <= r_serve_cnt;
            r_undo_valid   <= 1'b1;
            r_p1           <= w_p1_next;
            r_p2           <= w_p2_next;
            if (w_deuce || (r_serve_cnt == c_SC_LAST)) begin
                r_server    <= ~r_server;
                r_serve_cnt <= '0;
            end else begin
                r_serve_cnt <= r_serve_cnt + SC_W'(1);
            end
            if (w_win_next != c_WIN_NONE) begin
                r_winner <= w_win_next;
                r_state  <= c_ST_GAME_OVER;
            end
        end
    end

    assign p1_score_o = r_p1;
    assign p2_score_o = r_p2;
    assign server_o   = r_server;
    assign winner_o   = r_winner;
    assign state_o    = r_state;

endmodule : score_keeper_fsm
`default_nettype wire

// File: tb/tb_score_keeper_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_score_keeper_fsm
// Brief  : Scoreboard bench: a rules model queues expected outputs per button
//          action and they are compared once the DUT has settled.
// Rev    : 1.0
// ============================================================================
module tb_score_keeper_fsm;

    localparam int DB = 4;
    localparam int WS = 11;
    localparam int WM = 2;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_p1 = 1'b0, btn_p2 = 1'b0, btn_undo = 1'b0, btn_new = 1'b0;
    logic [7:0] p1_score, p2_score;
    logic       server, state;
    logic [1:0] winner;

    score_keeper_fsm #(
        .WIN_SCORE(WS), .WIN_MARGIN(WM), .SERVE_SWAP(SS), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .btn_p1_i(btn_p1), .btn_p2_i(btn_p2), .btn_undo_i(btn_undo), .btn_new_i(btn_new),
        .p1_score_o(p1_score), .p2_score_o(p2_score),
        .server_o(server), .winner_o(winner), .state_o(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p1; int p2; int srv; int win; int st;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference game model
    int m_p1, m_p2, m_srv, m_cnt, m_win, m_st, m_first, m_uv;
    int s_p1, s_p2, s_srv, s_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_p1 = 0; m_p2 = 0; m_srv = 0; m_cnt = 0; m_win = 0; m_st = 0;
        m_first = 0; m_uv = 0;
        s_p1 = 0; s_p2 = 0; s_srv = 0; s_cnt = 0;
    endtask

    task automatic m_point(input int who);
        int mine, other;
        bit deuce;
        if (m_st == 1) return;
        mine = (who == 1) ? m_p1 : m_p2;
        if (mine == 99) return;
        s_p1 = m_p1; s_p2 = m_p2; s_srv = m_srv; s_cnt = m_cnt; m_uv = 1;
        deuce = (m_p1 >= WS - 1) && (m_p2 >= WS - 1);
        if (who == 1) m_p1++; else m_p2++;
        if (deuce || m_cnt == SS - 1) begin
            m_srv = 1 - m_srv; m_cnt = 0;
        end else begin
            m_cnt++;
        end
        mine  = (who == 1) ? m_p1 : m_p2;
        other = (who == 1) ? m_p2 : m_p1;
        if (mine >= WS && mine >= other + WM) begin
            m_st = 1; m_win = who;
        end
    endtask

    task automatic m_event(input bit n, input bit u, input bit a, input bit b);
        if (n) begin
            m_p1 = 0; m_p2 = 0; m_win = 0; m_st = 0; m_uv = 0; m_cnt = 0;
            m_first = 1 - m_first; m_srv = m_first;
        end else if (u) begin
            if (m_uv == 1) begin
                m_p1 = s_p1; m_p2 = s_p2; m_srv = s_srv; m_cnt = s_cnt;
                m_uv = 0; m_st = 0; m_win = 0;
            end
        end else if (a) begin
            m_point(1);
        end else if (b) begin
            m_point(2);
        end
    endtask

    task automatic sb_push();
        exp_t e;
        e.p1 = m_p1; e.p2 = m_p2; e.srv = m_srv; e.win = m_win; e.st = m_st;
        sb_q.push_back(e);
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".p1"},     int'(p1_score), e.p1);
        check({tag, ".p2"},     int'(p2_score), e.p2);
        check({tag, ".server"}, int'(server),   e.srv);
        check({tag, ".winner"}, int'(winner),   e.win);
        check({tag, ".state"},  int'(state),    e.st);
    endtask

    // Holds the chosen raw buttons for `hold` cycles, releases, lets both
    // edges debounce, then compares against the model.
    task automatic press(input string tag, input bit n, input bit u,
                         input bit a, input bit b, input int hold);
        @(negedge clk);
        btn_new = n; btn_undo = u; btn_p1 = a; btn_p2 = b;
        repeat (hold) @(negedge clk);
        btn_new = 0; btn_undo = 0; btn_p1 = 0; btn_p2 = 0;
        if (hold >= DB + 4) m_event(n, u, a, b);
        sb_push();
        repeat (DB + 6) @(negedge clk);
        sb_compare(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        sb_push();
        sb_compare("reset");
        rst = 1'b0;

        press("glitch",  0, 0, 1, 0, 2);
        press("p1_hold", 0, 0, 1, 0, 20);
        press("srv_p1b", 0, 0, 1, 0, 10);
        press("srv_p2a", 0, 0, 0, 1, 10);
        press("srv_p2b", 0, 0, 0, 1, 10);

        for (int i = 0; i < 8; i++) begin
            press("to10_p1", 0, 0, 1, 0, 10);
            press("to10_p2", 0, 0, 0, 1, 10);
        end
        check("at_10_10", int'(p1_score) * 100 + int'(p2_score), 1010);
        press("deuce_11_10", 0, 0, 1, 0, 10);
        press("win_12_10",   0, 0, 1, 0, 10);
        check("win_state",   int'(state), 1);
        press("over_p2",     0, 0, 0, 1, 10);

        press("new1", 1, 0, 0, 0, 10);
        for (int i = 0; i < 5; i++)  press("g2_p2", 0, 0, 0, 1, 10);
        for (int i = 0; i < 11; i++) press("g2_p1", 0, 0, 1, 0, 10);
        check("win_11_5", int'(winner), 1);
        press("undo1", 0, 1, 0, 0, 10);
        press("undo2", 0, 1, 0, 0, 10);

        press("new2", 1, 0, 0, 0, 10);
        for (int i = 0; i < 3; i++) press("g3_p1", 0, 0, 1, 0, 10);
        for (int i = 0; i < 4; i++) press("g3_p2", 0, 0, 0, 1, 10);
        press("new_and_p1", 1, 0, 1, 0, 10);
        check("new_srv", int'(server), 1);
        press("undo_after_new", 0, 1, 0, 0, 10);

        for (int i = 0; i < 7; i++) press("g4_p1", 0, 0, 1, 0, 10);
        for (int i = 0; i < 3; i++) press("g4_p2", 0, 0, 0, 1, 10);

        // Asynchronous reset between clock edges while p2 is being held.
        @(negedge clk);
        btn_p2 = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        m_reset();
        sb_push();
        sb_compare("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (DB + 8) @(negedge clk);
        m_event(0, 0, 0, 1);
        sb_push();
        sb_compare("rst_held_p2");
        btn_p2 = 1'b0;
        repeat (DB + 8) @(negedge clk);
        sb_push();
        sb_compare("rst_release");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_score_keeper_fsm
`default_nettype wire
